// File: rtl/axis_bram_adapter.sv
// AXI4-Stream <-> wide single-port BRAM bridge: packs stream words into BRAM lines and serializes lines back out.
// Build option AXIS_BRAM_TLAST_FLUSH_EN: slave tlast ends a write transfer early (partial line zero-filled).
module axis_bram_adapter #(
   parameter int DATA_WIDTH     = 32,
   parameter int WORDS_PER_LINE = 36,
   parameter int ADDR_WIDTH     = 12
) (
   input  logic                                 s00_axis_aclk,
   input  logic                                 s00_axis_areset,
   output logic                                 BRAM_CLK,
   output logic                                 BRAM_EN,
   output logic                                 BRAM_WEN,
   output logic [ADDR_WIDTH-1:0]                BRAM_ADDR,
   output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] BRAM_IN,
   input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] BRAM_OUT,
   output logic                                 s00_axis_tready,
   input  logic [DATA_WIDTH-1:0]                s00_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]              s00_axis_tstrb,
   input  logic                                 s00_axis_tlast,
   input  logic                                 s00_axis_tvalid,
   output logic                                 m00_axis_tvalid,
   output logic [DATA_WIDTH-1:0]                m00_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]              m00_axis_tstrb,
   output logic                                 m00_axis_tlast,
   input  logic                                 m00_axis_tready,
   input  logic                                 rw,
   input  logic                                 addr_reload,
   input  logic [ADDR_WIDTH-1:0]                bram_start_addr,
   input  logic [ADDR_WIDTH-1:0]                bram_bound_addr
);

   // state     | meaning
   // IDLE      | after reset, waiting for addr_reload
   // WR_FILL   | accepting slave words into the line buffer
   // WR_STROBE | one-cycle BRAM write of the packed line
   // RD_ADDR   | one-cycle BRAM read strobe
   // RD_WAIT   | BRAM read latency; line captured at the end
   // RD_SEND   | serializing the line on the master stream
   // DONE      | window finished, waiting for addr_reload

   localparam int LINE_W = DATA_WIDTH * WORDS_PER_LINE;
   localparam int IDX_W  = $clog2(WORDS_PER_LINE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

   typedef enum logic [2:0] {
      IDLE, WR_FILL, WR_STROBE, RD_ADDR, RD_WAIT, RD_SEND, DONE
   } state_t;

   state_t                  state_q, state_nx;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_nx;
   logic [ADDR_WIDTH-1:0]   bound_q, bound_nx;
   logic [IDX_W-1:0]        idx_q, idx_nx;
   logic [LINE_W-1:0]       line_q, line_nx;
   logic                    flush_q, flush_nx;
   logic                    wr_hs, rd_hs;
   logic                    unused_ok;

   assign unused_ok = ^{s00_axis_tstrb, s00_axis_tlast};

   assign BRAM_CLK  = s00_axis_aclk;
   assign BRAM_ADDR = addr_q;
   assign BRAM_IN   = line_q;

   // tready/tvalid are registered copies of the state, so state alone qualifies a handshake
   assign wr_hs = (state_q == WR_FILL) && s00_axis_tvalid;
   assign rd_hs = (state_q == RD_SEND) && m00_axis_tready;

   always_comb begin
      state_nx = state_q;
      addr_nx  = addr_q;
      bound_nx = bound_q;
      idx_nx   = idx_q;
      line_nx  = line_q;
      flush_nx = flush_q;
      if (addr_reload) begin
         addr_nx  = bram_start_addr;
         bound_nx = bram_bound_addr;
         idx_nx   = '0;
         line_nx  = '0;
         flush_nx = 1'b0;
         state_nx = rw ? WR_FILL : RD_ADDR;
      end else begin
         case (state_q)
            WR_FILL: begin
               if (wr_hs) begin
                  line_nx[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = s00_axis_tdata;
`ifdef AXIS_BRAM_TLAST_FLUSH_EN
                  if (s00_axis_tlast) flush_nx = 1'b1;
`endif
                  if (idx_q == LAST_IDX || flush_nx) state_nx = WR_STROBE;
                  else idx_nx = idx_q + 1'b1;
               end
            end
            WR_STROBE: begin
               if (addr_q == bound_q || flush_q) begin
                  state_nx = DONE;
               end else begin
                  addr_nx  = addr_q + 1'b1;
                  idx_nx   = '0;
                  line_nx  = '0;
                  state_nx = WR_FILL;
               end
            end
            RD_ADDR: state_nx = RD_WAIT;
            RD_WAIT: begin
               line_nx  = BRAM_OUT;
               idx_nx   = '0;
               state_nx = RD_SEND;
            end
            RD_SEND: begin
               if (rd_hs) begin
                  if (idx_q == LAST_IDX) begin
                     if (addr_q == bound_q) begin
                        state_nx = DONE;
                     end else begin
                        addr_nx  = addr_q + 1'b1;
                        state_nx = RD_ADDR;
                     end
                  end else begin
                     idx_nx = idx_q + 1'b1;
                  end
               end
            end
            default: state_nx = state_q;
         endcase
      end
   end

   // Outputs are registered from the next-state values so they line up with the state they describe.
   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
      if (s00_axis_areset) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         bound_q         <= '0;
         idx_q           <= '0;
         line_q          <= '0;
         flush_q         <= 1'b0;
         BRAM_EN         <= 1'b0;
         BRAM_WEN        <= 1'b0;
         s00_axis_tready <= 1'b0;
         m00_axis_tvalid <= 1'b0;
         m00_axis_tdata  <= '0;
         m00_axis_tstrb  <= '0;
         m00_axis_tlast  <= 1'b0;
      end else begin
         state_q         <= state_nx;
         addr_q          <= addr_nx;
         bound_q         <= bound_nx;
         idx_q           <= idx_nx;
         line_q          <= line_nx;
         flush_q         <= flush_nx;
         BRAM_EN         <= (state_nx == WR_STROBE) || (state_nx == RD_ADDR);
         BRAM_WEN        <= (state_nx == WR_STROBE);
         s00_axis_tready <= (state_nx == WR_FILL);
         m00_axis_tvalid <= (state_nx == RD_SEND);
         m00_axis_tdata  <= (state_nx == RD_SEND) ?
                            line_nx[int'(idx_nx)*DATA_WIDTH +: DATA_WIDTH] : '0;
         m00_axis_tstrb  <= (state_nx == RD_SEND) ? '1 : '0;
         m00_axis_tlast  <= (state_nx == RD_SEND) && (idx_nx == LAST_IDX) &&
                            (addr_nx == bound_nx);
      end
   end

endmodule

// File: tb/tb_axis_bram_adapter.sv
// Self-checking bench for axis_bram_adapter: BRAM model, stream driver/sink, window/line reference model.
module tb_axis_bram_adapter;
   localparam int DW  = 32;
   localparam int WPL = 36;
   localparam int AW  = 12;
   localparam int LW  = DW * WPL;

   logic              s00_axis_aclk = 1'b0;
   logic              s00_axis_areset;
   logic              BRAM_CLK, BRAM_EN, BRAM_WEN;
   logic [AW-1:0]     BRAM_ADDR;
   logic [LW-1:0]     BRAM_IN, BRAM_OUT;
   logic              s00_axis_tready, s00_axis_tlast, s00_axis_tvalid;
   logic [DW-1:0]     s00_axis_tdata;
   logic [3:0]        s00_axis_tstrb;
   logic              m00_axis_tvalid, m00_axis_tlast, m00_axis_tready;
   logic [DW-1:0]     m00_axis_tdata;
   logic [3:0]        m00_axis_tstrb;
   logic              rw, addr_reload;
   logic [AW-1:0]     bram_start_addr, bram_bound_addr;

   always #5 s00_axis_aclk = ~s00_axis_aclk;

   axis_bram_adapter dut (
      .s00_axis_aclk(s00_axis_aclk), .s00_axis_areset(s00_axis_areset),
      .BRAM_CLK(BRAM_CLK), .BRAM_EN(BRAM_EN), .BRAM_WEN(BRAM_WEN),
      .BRAM_ADDR(BRAM_ADDR), .BRAM_IN(BRAM_IN), .BRAM_OUT(BRAM_OUT),
      .s00_axis_tready(s00_axis_tready), .s00_axis_tdata(s00_axis_tdata),
      .s00_axis_tstrb(s00_axis_tstrb), .s00_axis_tlast(s00_axis_tlast),
      .s00_axis_tvalid(s00_axis_tvalid),
      .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tdata(m00_axis_tdata),
      .m00_axis_tstrb(m00_axis_tstrb), .m00_axis_tlast(m00_axis_tlast),
      .m00_axis_tready(m00_axis_tready),
      .rw(rw), .addr_reload(addr_reload),
      .bram_start_addr(bram_start_addr), .bram_bound_addr(bram_bound_addr)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          wen;
      logic [AW-1:0] addr;
      logic [LW-1:0] data;
   } strobe_t;

   strobe_t       slog[$];
   strobe_t       ent;
   logic [LW-1:0] mem [0:4095];
   bit            written [0:4095];
   logic [LW-1:0] bram_q = '0;
   bit            force_pat = 1'b0;
   int            pat_mode = 0;
   int unsigned   pat_seed = 0;

   function automatic logic [LW-1:0] pat_line(int a, int mode, int unsigned seed);
      logic [LW-1:0] l;
      l = '0;
      if (mode == 0) l = {18{64'hCCCCCCCC_AAAAAAAA}};
      else for (int k = 0; k < WPL; k++)
         l[k*DW +: DW] = (seed * 32'h9E3779B1) ^ (a << 12) ^ (k * 32'h01000193);
      return l;
   endfunction

   function automatic logic [LW-1:0] bram_line(int a);
      if (force_pat || !written[a]) return pat_line(a, pat_mode, pat_seed);
      return mem[a];
   endfunction

   // Synchronous single-port BRAM with one-cycle read latency; logs every strobe.
   always @(posedge s00_axis_aclk) begin
      if (BRAM_EN) begin
         ent.wen  = BRAM_WEN;
         ent.addr = BRAM_ADDR;
         ent.data = BRAM_IN;
         slog.push_back(ent);
         if (BRAM_WEN) begin
            mem[BRAM_ADDR]     <= BRAM_IN;
            written[BRAM_ADDR] <= 1'b1;
         end else begin
            bram_q <= bram_line(int'(BRAM_ADDR));
         end
      end
   end
   assign BRAM_OUT = bram_q;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic chk_line(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         for (int k = 0; k < WPL; k++) begin
            if (act[k*DW +: DW] !== exp[k*DW +: DW]) begin
               $display("FAIL %s word %0d act=%h exp=%h", name, k, act[k*DW +: DW], exp[k*DW +: DW]);
               break;
            end
         end
      end
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_bram_en"}, BRAM_EN, 0);
      chk({tag, "_bram_wen"}, BRAM_WEN, 0);
      chk({tag, "_bram_addr"}, BRAM_ADDR, 0);
      chk_line({tag, "_bram_in"}, BRAM_IN, '0);
      chk({tag, "_tready"}, s00_axis_tready, 0);
      chk({tag, "_tvalid"}, m00_axis_tvalid, 0);
      chk({tag, "_tdata"}, m00_axis_tdata, 0);
      chk({tag, "_tstrb"}, m00_axis_tstrb, 0);
      chk({tag, "_tlast"}, m00_axis_tlast, 0);
   endtask

   function automatic int win_lines(int s, int b);
      return ((b - s + 4096) % 4096) + 1;
   endfunction

   task automatic do_reload(logic mode, int s, int b);
      @(negedge s00_axis_aclk);
      rw = mode;
      bram_start_addr = AW'(s);
      bram_bound_addr = AW'(b);
      addr_reload = 1'b1;
      s00_axis_tvalid = 1'b0;
      s00_axis_tlast = 1'b0;
      @(negedge s00_axis_aclk);
      addr_reload = 1'b0;
   endtask

   // dmode: 0 = 0/FFFFFFFF alternating, 1 = random, 2 = 36 x 0/F then AAAAAAAA/CCCCCCCC
   task automatic run_write(string tag, int s, int b, int nwords, int tlast_at, bit gap,
                            int dmode, int exp_lines);
      logic [DW-1:0] w[$];
      logic [LW-1:0] line;
      int  L, consumed, nl, i, cyc, exp_n, nchk;
      bit  done, hs, v, flush_hit;
      for (int j = 0; j < nwords; j++) begin
         if (dmode == 0)      w.push_back((j % 2) ? 32'hFFFFFFFF : 32'h0);
         else if (dmode == 2) w.push_back((j < 36) ? ((j % 2) ? 32'hFFFFFFFF : 32'h0)
                                                   : ((j % 2) ? 32'hCCCCCCCC : 32'hAAAAAAAA));
         else                 w.push_back($urandom);
      end
      L = win_lines(s, b);
      flush_hit = 1'b0;
`ifdef AXIS_BRAM_TLAST_FLUSH_EN
      flush_hit = (tlast_at >= 0) && (tlast_at < WPL * L) && (tlast_at < nwords);
`endif
      if (flush_hit) begin
         consumed = tlast_at + 1;
         nl = tlast_at / WPL + 1;
         done = 1'b1;
      end else begin
         consumed = (nwords < WPL * L) ? nwords : WPL * L;
         nl = consumed / WPL;
         done = (nl == L);
      end
      exp_n = (exp_lines >= 0) ? exp_lines : nl;
      slog.delete();
      do_reload(1'b1, s, b);
      i = 0;
      cyc = 0;
      while (i < consumed && cyc < 4000) begin
         v = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
         s00_axis_tvalid = v;
         s00_axis_tdata  = w[i];
         s00_axis_tlast  = (i == tlast_at);
         hs = v && s00_axis_tready;
         @(negedge s00_axis_aclk);
         cyc++;
         if (hs) begin
            i++;
            if ((i % WPL == 0) || (flush_hit && i == consumed)) begin
               chk({tag, "_strobe_wen"}, BRAM_WEN, 1);
               chk({tag, "_strobe_tready"}, s00_axis_tready, 0);
            end
         end
      end
      s00_axis_tvalid = 1'b0;
      s00_axis_tlast  = 1'b0;
      if (i < consumed) chk({tag, "_timeout_words"}, i, consumed);
      repeat (4) @(negedge s00_axis_aclk);
      chk({tag, "_write_count"}, slog.size(), exp_n);
      nchk = (slog.size() < nl) ? slog.size() : nl;
      for (int l = 0; l < nchk; l++) begin
         for (int k = 0; k < WPL; k++)
            line[k*DW +: DW] = (WPL*l + k < consumed) ? w[WPL*l + k] : 32'h0;
         chk({tag, "_wr_wen"}, slog[l].wen, 1);
         chk({tag, "_wr_addr"}, slog[l].addr, (s + l) % 4096);
         chk_line({tag, "_wr_data"}, slog[l].data, line);
      end
      chk({tag, "_tready_after"}, s00_axis_tready, !done);
   endtask

   // rmode: 0 = tready always 1, 1 = toggles every cycle, 2 = random
   task automatic run_read(string tag, int s, int b, int rmode, bit fpat, int pmode, int exp_lines);
      logic [DW-1:0] expw[$];
      logic [LW-1:0] line;
      logic [DW-1:0] held;
      int  L, nbeats, got, cyc, lat, exp_n;
      bit  r, tog, stall;
      force_pat = fpat;
      pat_mode  = pmode;
      pat_seed  = $urandom;
      L = win_lines(s, b);
      nbeats = WPL * L;
      exp_n = (exp_lines >= 0) ? exp_lines : L;
      for (int l = 0; l < L; l++) begin
         line = bram_line((s + l) % 4096);
         for (int k = 0; k < WPL; k++) expw.push_back(line[k*DW +: DW]);
      end
      slog.delete();
      m00_axis_tready = 1'b0;
      do_reload(1'b0, s, b);
      lat = 1;
      while (!m00_axis_tvalid && lat < 10) begin
         @(negedge s00_axis_aclk);
         lat++;
      end
      chk({tag, "_first_valid_latency"}, lat, 3);
      got = 0;
      cyc = 0;
      tog = 1'b0;
      stall = 1'b0;
      held = '0;
      while (got < nbeats && cyc < 6000) begin
         case (rmode)
            0:       r = 1'b1;
            1:       r = tog;
            default: r = ($urandom_range(0, 1) == 1);
         endcase
         tog = ~tog;
         m00_axis_tready = r;
         if (stall) begin
            chk({tag, "_stall_valid"}, m00_axis_tvalid, 1);
            chk({tag, "_stall_data"}, m00_axis_tdata, held);
         end
         if (m00_axis_tvalid && r) begin
            chk({tag, "_beat_data"}, m00_axis_tdata, expw[got]);
            chk({tag, "_beat_tlast"}, m00_axis_tlast, (got == nbeats - 1));
            chk({tag, "_beat_tstrb"}, m00_axis_tstrb, 4'hF);
            got++;
            stall = 1'b0;
         end else if (m00_axis_tvalid) begin
            stall = 1'b1;
            held = m00_axis_tdata;
         end else begin
            stall = 1'b0;
         end
         @(negedge s00_axis_aclk);
         cyc++;
      end
      if (got < nbeats) chk({tag, "_timeout_beats"}, got, nbeats);
      m00_axis_tready = 1'b1;
      repeat (4) @(negedge s00_axis_aclk);
      chk({tag, "_tvalid_after"}, m00_axis_tvalid, 0);
      chk({tag, "_strobe_count"}, slog.size(), exp_n);
      for (int l = 0; l < slog.size() && l < L; l++) begin
         chk({tag, "_rd_wen"}, slog[l].wen, 0);
         chk({tag, "_rd_addr"}, slog[l].addr, (s + l) % 4096);
      end
   endtask

   typedef struct {
      bit rw;
      int s;
      int b;
      int nwords;
      int tlast_at;
      int mode;
      int dmode;
      int exp_lines;
   } vec_t;

   vec_t vecs[9];

   initial begin
      // rw, start, bound, nwords, tlast_at, mode (gap / ready), data/pattern mode, expected lines
      vecs[0] = '{1'b1, 3,    7,   180, -1, 0, 0, 5};
      vecs[1] = '{1'b0, 6,    7,   0,   -1, 0, 0, 2};
      vecs[2] = '{1'b0, 6,    7,   0,   -1, 1, 0, 2};
      vecs[3] = '{1'b1, 4094, 1,   144, -1, 1, 1, 4};
      vecs[4] = '{1'b1, 100,  100, 36,  -1, 1, 1, 1};
      vecs[5] = '{1'b0, 4095, 0,   0,   -1, 2, 1, 2};
      vecs[6] = '{1'b0, 9,    9,   0,   -1, 0, 1, 1};
      vecs[7] = '{1'b1, 3,    7,   72,  71, 0, 2, 2};
      vecs[8] = '{1'b1, 30,   30,  36,  9,  0, 1, 1};

      s00_axis_areset = 1'b1;
      s00_axis_tdata = '0; s00_axis_tstrb = '0; s00_axis_tlast = 1'b0; s00_axis_tvalid = 1'b0;
      m00_axis_tready = 1'b0;
      rw = 1'b0; addr_reload = 1'b0; bram_start_addr = '0; bram_bound_addr = '0;
      repeat (3) @(negedge s00_axis_aclk);
      chk_all_zero("reset");
      s00_axis_areset = 1'b0;
      s00_axis_tvalid = 1'b1;
      m00_axis_tready = 1'b1;
      repeat (5) @(negedge s00_axis_aclk);
      chk_all_zero("idle_hold");
      s00_axis_tvalid = 1'b0;

      for (int t = 0; t < 9; t++) begin
         if (vecs[t].rw)
            run_write($sformatf("vec%0d", t), vecs[t].s, vecs[t].b, vecs[t].nwords,
                      vecs[t].tlast_at, vecs[t].mode != 0, vecs[t].dmode, vecs[t].exp_lines);
         else
            run_read($sformatf("vec%0d", t), vecs[t].s, vecs[t].b, vecs[t].mode, 1'b1,
                     vecs[t].dmode, vecs[t].exp_lines);
      end

      // reload mid-line: the 10 words already taken must never reach the BRAM
      slog.delete();
      do_reload(1'b1, 20, 21);
      for (int j = 0; j < 10; j++) begin
         s00_axis_tvalid = 1'b1;
         s00_axis_tdata  = 32'h5A5A0000 + j;
         @(negedge s00_axis_aclk);
      end
      s00_axis_tvalid = 1'b0;
      chk("abort_no_write", slog.size(), 0);
      run_write("abort_restart", 50, 50, 36, -1, 1'b0, 1, 1);

      // write then read back random windows, some wrapping through 4095
      for (int it = 0; it < 6; it++) begin
         int s, len, b;
         s   = $urandom_range(0, 4095);
         len = $urandom_range(1, 3);
         b   = (s + len - 1) % 4096;
         run_write($sformatf("rnd%0d_wr", it), s, b, WPL * len, -1, 1'b1, 1, -1);
         run_read($sformatf("rnd%0d_rd", it), s, b, 2, 1'b0, 1, -1);
      end

      // reset in the middle of a read burst
      do_reload(1'b0, 200, 202);
      m00_axis_tready = 1'b1;
      repeat (20) @(negedge s00_axis_aclk);
      s00_axis_areset = 1'b1;
      #1;
      chk_all_zero("midrst_in");
      @(negedge s00_axis_aclk);
      s00_axis_areset = 1'b0;
      repeat (3) @(negedge s00_axis_aclk);
      chk_all_zero("midrst_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog act=timeout exp=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
